// File: rtl/seq_detector_n.sv
// Purpose : Moore serial detector for a WIDTH-bit PATTERN with overlap select and a saturating match counter.
// Latency : F and match_cnt update on the edge that consumes the final pattern bit and are visible the next cycle.
// Backpr. : none; en=0 stalls the bit stream, holding S, F and match_cnt, and x is ignored.
//
// Ports:
//   CLK       rising-edge clock
//   RESET     synchronous active-low reset (clears S and match_cnt)
//   en        bit valid; x consumed only when high
//   x         serial data bit, PATTERN[WIDTH-1] expected first
//   overlap   1 = reuse the matched suffix, 0 = restart after a match
//   clr_cnt   synchronous clear of match_cnt, wins over a same-edge match
//   F         match flag, high iff S == WIDTH
//   S         number of pattern prefix bits currently matched (0..WIDTH)
//   match_cnt saturating count of completed matches
module seq_detector_n #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               SW      = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             F,
    output logic [SW-1:0]    S,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               NSTATE  = WIDTH + 1;
    localparam int               TBL_W   = 2 * NSTATE * SW;
    localparam logic [SW-1:0]    S_FULL  = SW'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // KMP transition table, built once from PATTERN. Entry (s, b) holds the
    // longest pattern prefix that is a suffix of "first s pattern bits, then b".
    // The last s consumed bits are known to equal that prefix, so no bit
    // history needs to be stored. Entries are packed as SW-bit fields at
    // index 2*s + b.
    function automatic logic [TBL_W-1:0] build_tbl();
        logic [TBL_W-1:0] tbl;
        int               best;
        logic             ok;
        tbl = '0;
        for (int s = 0; s <= WIDTH; s++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int k = 1; k <= WIDTH; k++) begin
                    if (k <= s + 1) begin
                        // new bit must equal pattern bit k-1 (time order)
                        ok = (PATTERN[WIDTH-k] == b[0]);
                        // the k-1 bits before it are pattern positions s-k+1 .. s-1
                        for (int j = 0; j < k - 1; j++) begin
                            if (PATTERN[WIDTH-1-(s-k+1+j)] != PATTERN[WIDTH-1-j]) begin
                                ok = 1'b0;
                            end
                        end
                        if (ok) begin
                            best = k;
                        end
                    end
                end
                tbl[(2*s+b)*SW +: SW] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NXT = build_tbl();

    logic [SW-1:0]    s_cur;
    logic [SW-1:0]    s_lkp;
    logic [SW-1:0]    s_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        s_cur   = S;
        s_lkp   = '0;
        s_nxt   = S;
        cnt_nxt = match_cnt;

        // Non-overlapping mode discards the matched bits: leaving the full
        // state behaves exactly like starting from state 0.
        if (S == S_FULL && !overlap) begin
            s_cur = '0;
        end

        for (int i = 0; i < NSTATE; i++) begin
            if (s_cur == SW'(i)) begin
                s_lkp = x ? NXT[(2*i+1)*SW +: SW] : NXT[(2*i)*SW +: SW];
            end
        end

        if (en) begin
            s_nxt = s_lkp;
            if (s_lkp == S_FULL && match_cnt != CNT_MAX) begin
                cnt_nxt = match_cnt + CNT_W'(1);
            end
        end

        // clear acts with or without en and beats a same-edge match
        if (clr_cnt) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            S         <= '0;
            match_cnt <= '0;
        end else begin
            S         <= s_nxt;
            match_cnt <= cnt_nxt;
        end
    end

    // Moore output: decoded from the state register only
    assign F = (S == S_FULL);

endmodule

// File: doc/seq_detector_n.md
Name: seq_detector_n

Overview:
- Parametrised Moore serial pattern detector; successor to the fixed 3-bit hand-built state machines in the lab set.
- Detects an arbitrary WIDTH-bit pattern on serial input x.
- Selectable overlapping or non-overlapping mode, clock enable, and a saturating match counter.
- Exposes its state on S for observation, like the earlier machines.

Parameters:
- WIDTH, 4, pattern length in bits (WIDTH >= 1).
- PATTERN, 4'b1011, target sequence, WIDTH bits. PATTERN[WIDTH-1] is the first bit received.
- CNT_W, 8, match counter width (CNT_W >= 1).
- SW, $clog2(WIDTH+1), state width (derived, not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- en  input  1  bit-valid / clock enable; x is consumed only when en=1.
- x  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr_cnt  input  1  synchronous clear of match_cnt.
- F  output  1  match flag (Moore): 1 iff S == WIDTH.
- S  output  SW  current state = number of pattern prefix bits currently matched (0..WIDTH).
- match_cnt  output  CNT_W  saturating count of completed matches.

Behaviour:
- Reset: RESET=0 at a rising edge forces S=0, F=0, match_cnt=0. It overrides en, clr_cnt and any match in progress. It is never asynchronous.
- State meaning: S=k means the last k consumed bits equal PATTERN[WIDTH-1 -: k], and k is the largest such value <= WIDTH.
- Transition when en=1, for state s and bit b:
  - s < WIDTH: S' = largest k <= s+1 such that the last k consumed bits, including b, equal the first k pattern bits. This is the KMP failure-function transition.
  - s == WIDTH, overlap=1: S' is computed over the full history, so the matched pattern's suffix is reused.
  - s == WIDTH, overlap=0: S' = transition from state 0 with bit b. The matched bits are discarded.
- overlap is sampled only on the edge leaving S=WIDTH; changing it at other times has no effect.
- en=0: S, F and match_cnt hold; x is ignored.
- F is a pure decode of registered S, with no combinational path from x.
  - Latency: F rises in the cycle after the edge that consumed the final pattern bit.
  - F stays high exactly one enabled bit-time, unless the next bit completes another match. Overlap mode with a self-overlapping pattern, e.g. all-ones, can hold F high continuously.
- match_cnt:
  - Increments by 1 on the same edge that S' becomes WIDTH, so it updates together with F rising.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 sets match_cnt=0 at the edge. If a match completes on the same edge, clear wins and the result is 0.
  - clr_cnt acts regardless of en.
- Transitions are computed from PATTERN at elaboration (next-state function or history compare). No run-time pattern load.
- All outputs are registered or decoded from registers; there are no latches.

Test Plan:
- PATTERN=1011, overlap=1, en=1, x=1,0,1,1,0,1,1 -> S sequence 1,2,3,4,2,3,4; F high after bit 4 and after bit 7; match_cnt=2.
- Same stream, overlap=0 -> S sequence 1,2,3,4,0,1,1; F high only after bit 4; match_cnt=1.
- x=1,0,1 with en=1, then en=0 for 3 cycles with x toggling, then en=1 with x=1 -> S holds at 3 during the stall, then reaches 4; F=1 one cycle after the final bit.
- CNT_W=2, PATTERN=1, overlap=1, x=1 for 6 enabled cycles -> match_cnt reads 1,2,3,3,3,3; F stays high.
- Reach S=3 with PATTERN=1011, then drive RESET=0 for one edge with x=1 -> S=0, F=0, match_cnt=0. Then feeding 1,0,1,1 gives a fresh match.
- Assert clr_cnt on the edge the 4th bit of 1011 is consumed, with match_cnt=5 beforehand -> match_cnt=0 and F=1 the next cycle. The following match gives match_cnt=1.
